// File: rtl/soc_system_pkg.sv
// Shared types and default 50 MHz timing constants for the PLL reset sequencer.
package soc_system_pkg;

    typedef enum logic [2:0] {
        S_PLLRST    = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    localparam int DEF_PLL_RST_CYCLES = 16;
    localparam int DEF_LOCK_TIMEOUT   = 65536;
    localparam int DEF_STABLE_CYCLES  = 1024;
    localparam int DEF_MAX_RETRIES    = 3;
    localparam int DEF_CNT_W          = 17;

endpackage

// File: rtl/soc_system_sync2.sv
// Two-flop single-bit synchroniser into the clk domain; output lags input by 2 cycles.
module soc_system_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            dout <= 1'b0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/soc_system_pll_reset_seq.sv
// PLL reset sequencer: pulses PLL reset, waits for lock with timeout/retry, qualifies lock,
// then releases sys_rst. Outputs are registered from next-state so they move with the state.
module soc_system_pll_reset_seq
    import soc_system_pkg::*;
#(
    parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int MAX_RETRIES    = DEF_MAX_RETRIES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       soft_req,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic [7:0] relock_cnt
);

    localparam int RET_W = $clog2(MAX_RETRIES + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RET_W-1:0]   retries_q, retries_d, retries_inc;
    logic [7:0]         relock_d;
    logic               locked_s;

    soc_system_sync2 u_lock_sync (
        .clk  (refclk),
        .rst  (rst),
        .din  (pll_locked),
        .dout (locked_s)
    );

    assign retries_inc = retries_q + RET_W'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retries_d = retries_q;
        relock_d  = relock_cnt;
        unique case (state_q)
            S_PLLRST: begin
                if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) state_d = S_WAIT_LOCK;
                else                                     cnt_d   = cnt_q + CNT_W'(1);
            end
            S_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = S_STABLE;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    retries_d = retries_inc;
                    state_d   = (retries_inc == RET_W'(MAX_RETRIES)) ? S_FAIL : S_PLLRST;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STABLE: begin
                if (!locked_s) begin
                    retries_d = retries_inc;
                    state_d   = (retries_inc == RET_W'(MAX_RETRIES)) ? S_FAIL : S_PLLRST;
                end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                    state_d   = S_RUN;
                    retries_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RUN: begin
                // Lock loss wins over soft_req only in that it is also counted.
                if (!locked_s) begin
                    state_d = S_PLLRST;
                    if (relock_cnt != 8'hFF) relock_d = relock_cnt + 8'd1;
                end
                if (!locked_s || soft_req) begin
                    state_d   = S_PLLRST;
                    retries_d = '0;
                end
            end
            S_FAIL: begin
                if (soft_req) begin
                    state_d   = S_PLLRST;
                    retries_d = '0;
                end
            end
            default: state_d = S_PLLRST;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q    <= S_PLLRST;
            cnt_q      <= '0;
            retries_q  <= '0;
            relock_cnt <= 8'd0;
            pll_rst    <= 1'b1;
            sys_rst    <= 1'b1;
            ready      <= 1'b0;
            fail       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            retries_q  <= retries_d;
            relock_cnt <= relock_d;
            pll_rst    <= (state_d == S_PLLRST) || (state_d == S_FAIL);
            sys_rst    <= (state_d != S_RUN);
            ready      <= (state_d == S_RUN);
            fail       <= (state_d == S_FAIL);
        end
    end

endmodule
